// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and
// frame-shape constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;
    localparam int unsigned FRAME_BITS           = 1 + DATA_BITS + STOP_BITS;

    // Width needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the serializer. The head entry is read
// combinationally so the FSM can load it on the same edge it pops.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// serializer with a registered line output and back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned        BAUD_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  en_q;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [7:0]                  fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        bit_done;

    // en_q keeps tx_ready low throughout reset and only from registers.
    assign tx_ready  = en_q && !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign tx        = tx_q;
    assign bit_done  = (baud_q == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (tx_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            en_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single-frame vectors plus
// back-to-back, FIFO-full and mid-frame reset sequences, with a receiver.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    int frame_starts[$];
    int frames_started = 0;
    int frames_done    = 0;
    int cyc            = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a byte and hold it until accepted; waits = edges spent with tx_ready low.
    task automatic push_byte(input logic [7:0] b, output int waits);
        tx_data  = b;
        tx_valid = 1'b1;
        waits    = 0;
        while (!tx_ready && waits < 500) begin
            step();
            waits++;
        end
        if (!tx_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: byte 0x%0h not accepted, tx_ready=%0b", b, tx_ready);
            tx_valid = 1'b0;
        end else begin
            sb.push_back(b);
            step();
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 1000) begin
            step();
            t++;
        end
        check("wait_idle_busy", busy, 1'b0);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 2000) begin
            step();
            t++;
        end
        check("frames_done", frames_done, target);
    endtask

    // Receiver: samples every cycle at the falling edge and checks each frame
    // sample-by-sample against the next byte from the scoreboard.
    initial begin : rx_monitor
        bit         in_frame;
        bit         have_exp;
        int         idx;
        int         bad;
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       eb;
        in_frame = 0;
        have_exp = 0;
        idx      = 0;
        bad      = 0;
        got      = 8'h00;
        exp_b    = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                in_frame = 0;
            end else begin
                if (!in_frame && tx == 1'b0) begin
                    in_frame = 1;
                    idx      = 0;
                    bad      = 0;
                    got      = 8'h00;
                    frames_started++;
                    frame_starts.push_back(cyc);
                    if (sb.size() == 0) begin
                        have_exp = 0;
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: start bit with empty scoreboard at cycle %0d", cyc);
                    end else begin
                        exp_b    = sb.pop_front();
                        have_exp = 1;
                    end
                end
                if (in_frame) begin
                    if (idx < CPB)            eb = 1'b0;
                    else if (idx < 9 * CPB)   eb = exp_b[(idx - CPB) / CPB];
                    else                      eb = 1'b1;
                    if (tx !== eb) bad++;
                    if (idx >= CPB && idx < 9 * CPB && (idx % CPB) == CPB / 2)
                        got[(idx - CPB) / CPB] = tx;
                    idx++;
                    if (idx == FRAME) begin
                        in_frame = 0;
                        frames_done++;
                        if (have_exp) begin
                            check("rx_byte", got, exp_b);
                            check("rx_bad_samples", bad, 0);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         w;
        int         waits6[6];
        int         base;
        int         base_started;
        int         t;
        logic [9:0] fr;
        logic [7:0] seq6[6];

        vecs[0] = '{8'h4A, 10'b1010010100};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'hA5, 10'b1101001010};

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", tx_ready, 1'b0);
        rst = 1'b1;
        step();
        check("rel_ready", tx_ready, 1'b1);
        check("rel_tx", tx, 1'b1);
        repeat (5) step();
        check("rel_no_frame", frames_started, 0);
        check("rel_busy", busy, 1'b0);

        // Single-frame table: exact shape, latency and busy fall
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            push_byte(vecs[i].data, w);
            tx_valid = 1'b0;
            fr = '0;
            for (int s = 0; s < FRAME; s++) begin
                step();
                if (s == 0) check("vec_latency_tx_low", tx, 1'b0);
                if ((s % CPB) == CPB / 2) fr[s / CPB] = tx;
            end
            check("vec_frame", fr, vecs[i].frame);
            check("vec_busy_in_stop", busy, 1'b1);
            step();
            check("vec_busy_after", busy, 1'b0);
            check("vec_tx_idle", tx, 1'b1);
        end

        // Back-to-back frames with no idle gap
        wait_idle();
        frame_starts.delete();
        base = frames_done;
        push_byte(8'h70, w); check("b2b_wait0", w, 0);
        push_byte(8'h8B, w); check("b2b_wait1", w, 0);
        push_byte(8'hC1, w); check("b2b_wait2", w, 0);
        tx_valid = 1'b0;
        wait_frames(base + 3);
        check("b2b_starts", frame_starts.size(), 3);
        if (frame_starts.size() >= 3) begin
            check("b2b_gap01", frame_starts[1] - frame_starts[0], FRAME);
            check("b2b_gap12", frame_starts[2] - frame_starts[1], FRAME);
        end

        // FIFO fill: tx_ready drops, push stalls across the STOP pop edge
        wait_idle();
        frame_starts.delete();
        base = frames_done;
        seq6[0] = 8'h11; seq6[1] = 8'h22; seq6[2] = 8'h33;
        seq6[3] = 8'h44; seq6[4] = 8'h55; seq6[5] = 8'h66;
        for (int k = 0; k < 6; k++) begin
            push_byte(seq6[k], waits6[k]);
            if (k == 4) check("full_ready_low", tx_ready, 1'b0);
        end
        tx_valid = 1'b0;
        for (int k = 0; k < 5; k++) check("fill_wait", waits6[k], 0);
        check("full_stall_edges", waits6[5], 37);
        wait_frames(base + 6);
        check("fill_starts", frame_starts.size(), 6);
        if (frame_starts.size() >= 6) begin
            for (int k = 1; k < 6; k++)
                check("fill_gap", frame_starts[k] - frame_starts[k-1], FRAME);
        end
        check("sb_drained", sb.size(), 0);

        // Reset in the middle of a frame discards it and the buffered bytes
        wait_idle();
        base_started = frames_started;
        push_byte(8'h55, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        tx_valid = 1'b0;
        t = 0;
        while (frames_started == base_started && t < 100) begin
            step();
            t++;
        end
        check("abort_frame_began", frames_started, base_started + 1);
        repeat (13) step();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        sb.delete();
        step();
        check("abort_tx_high", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", tx_ready, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("abort_rel_ready", tx_ready, 1'b1);
        repeat (60) step();
        check("abort_no_replay", frames_started, base_started + 1);
        check("abort_idle_tx", tx, 1'b1);
        check("abort_idle_busy", busy, 1'b0);
        base = frames_done;
        push_byte(8'hA5, w);
        tx_valid = 1'b0;
        wait_frames(base + 1);
        wait_idle();
        check("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data presented this cycle.
REQ-007 tx_ready  output  1  buffer can accept a byte this cycle.
REQ-008 tx  output  1  serial line, 8N1, idle high; registered output.
REQ-009 busy  output  1  frame in progress or buffer non-empty.

Function
REQ-010 Byte accepted on a rising edge where tx_valid && tx_ready; it SHALL be written to the FIFO tail.
REQ-011 tx_ready SHALL equal !full, with full derived from registered FIFO count only (no combinational path from tx_valid).
REQ-012 tx_valid while tx_ready low SHALL be ignored; no byte lost or duplicated.
REQ-013 FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx high; if FIFO non-empty, pop head into shift register, drive tx low, go to START on the same edge.
REQ-015 START: tx held low exactly CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit bit index; after bit 7, go to STOP.
REQ-017 STOP: tx high exactly CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop and enter START directly (no idle cycle between frames); else IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-019 Latency: byte accepted on edge N into empty FIFO with FSM in IDLE -> tx low from edge N+1.
REQ-020 Push and pop on the same edge SHALL both take effect; count unchanged; with FIFO full, the pop does not make tx_ready high in that cycle.
REQ-021 Baud counter counts 0..CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 busy = (state != IDLE) || (count != 0), registered-derived.
REQ-023 Bytes SHALL leave in acceptance order.

Reset
REQ-024 rst low at a rising edge: state IDLE, tx 1, busy 0, tx_ready 0 while rst low, FIFO count/pointers 0, baud counter 0, bit index 0.
REQ-025 Reset mid-frame SHALL abort the frame; tx high from the next edge; buffered bytes discarded.
REQ-026 First rising edge with rst high: tx_ready 1, no frame starts until a byte is accepted.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum, DEFAULT_CLKS_PER_BIT (868), and the frame-length constants (8 data bits, 1 stop bit).
REQ-028 Buffer SHALL be a separate sub-module uart_tx_fifo (push/pop, full/empty/count, synchronous active-low reset), instantiated once.
REQ-029 Memory contents not reset; only pointers and count.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Reset released, single push 0x4A -> tx low 4 cycles, then bits 0,1,0,1,0,0,1,0 for 4 cycles each, then high 4 cycles; 40 cycles total; busy falls right after.
REQ-031 Push 0x70, 0x8B, 0xC1 back-to-back -> three contiguous 40-cycle frames, no idle cycle between, decoded by bench receiver in order 0x70, 0x8B, 0xC1.
REQ-032 Hold tx_valid high with 6 distinct bytes while the first frame is in flight -> tx_ready low after the FIFO fills with 4 bytes, all 6 bytes transmitted exactly once, in order.
REQ-033 rst low at cycle 15 of a 0x55 frame -> tx high on the next edge, busy 0, buffered bytes not transmitted after release; next push 0xA5 transmits cleanly.
REQ-034 Push on the same edge that STOP pops with a full FIFO -> count stays 4, tx_ready stays low that cycle, no byte lost.
